collision_event_sequencer: RTL

COLLISION_EVENT_SEQUENCER -- requirements
Module: collision_event_sequencer

---
 rtl/galaga_lib.sv | 30 +++
 rtl/collision_event_sequencer_if.sv | 13 +
 rtl/lsb_first_enc.sv | 22 ++
 rtl/collision_event_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/galaga_lib.sv
// rtl/galaga_lib.sv - shared game constants, event encoding and score arithmetic
package galaga_lib;

   localparam int NE_DEF = 8;
   localparam int NP_DEF = 4;

   localparam logic [15:0] SCORE_PER_KILL = 16'd50;
   localparam logic [1:0]  START_LIVES    = 2'd3;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_SHIP  = 2'd1,
      EVT_ESHIP = 2'd2,
      EVT_PROJ  = 2'd3
   } evt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ISSUE,
      ST_GAMEOVER
   } seq_state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/collision_event_sequencer_if.sv
// rtl/collision_event_sequencer_if.sv - valid/ready event channel to the explosion/despawn logic
interface collision_event_sequencer_if;
   import galaga_lib::*;

   logic       evt_valid;
   logic       evt_ready;
   evt_t       evt_type;
   logic [3:0] evt_idx;

   modport master (output evt_valid, output evt_type, output evt_idx, input evt_ready);
   modport slave  (input evt_valid, input evt_type, input evt_idx, output evt_ready);

endinterface

// File: rtl/lsb_first_enc.sv
// rtl/lsb_first_enc.sv - reports whether any bit is set and the index of the lowest set bit
module lsb_first_enc #(
   parameter int W = 8
) (
   input  logic [W-1:0] in_vec,
   output logic         found,
   output logic [3:0]   idx
);

   // Scanning downward lets the lowest set bit be the last writer.
   always_comb begin
      found = 1'b0;
      idx   = 4'd0;
      for (int i = W - 1; i >= 0; i--) begin
         if (in_vec[i]) begin
            found = 1'b1;
            idx   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/collision_event_sequencer.sv
// rtl/collision_event_sequencer.sv - latches per-frame collision flags and issues them one event at a time
module collision_event_sequencer
   import galaga_lib::*;
#(
   parameter int NE = NE_DEF,
   parameter int NP = NP_DEF
) (
   input  logic                        pixel_clk,
   input  logic                        Reset_n,
   input  logic                        frame_clk,
   input  logic                        ShipColl,
   input  logic [NP-1:0]               ProjColl,
   input  logic [NE-1:0]               EShipColl,
   collision_event_sequencer_if.master evt,
   output logic [15:0]                 score,
   output logic [1:0]                  lives,
   output logic                        game_over,
   output logic                        overrun
);

   seq_state_t  state_q, state_d;
   logic        fc_sample_q, fc_sample_d;
   logic        pend_ship_q, pend_ship_d;
   logic [NE-1:0] pend_eship_q, pend_eship_d;
   logic [NP-1:0] pend_proj_q, pend_proj_d;
   evt_t        evt_type_q, evt_type_d;
   logic [3:0]  evt_idx_q, evt_idx_d;
   logic [15:0] score_q, score_d;
   logic [1:0]  lives_q, lives_d;
   logic        game_over_q, game_over_d;
   logic        overrun_q, overrun_d;

   logic        frame_edge, merge, any_new, kill;
   logic        clr_ship;
   logic [NE-1:0] clr_eship;
   logic [NP-1:0] clr_proj;
   logic        e_found, p_found;
   logic [3:0]  e_idx, p_idx;

   lsb_first_enc #(.W(NE)) u_eship_enc (.in_vec(pend_eship_q), .found(e_found), .idx(e_idx));
   lsb_first_enc #(.W(NP)) u_proj_enc  (.in_vec(pend_proj_q),  .found(p_found), .idx(p_idx));

   assign any_new = ShipColl | (|EShipColl) | (|ProjColl);

   always_comb begin
      state_d     = state_q;
      fc_sample_d = frame_clk;
      evt_type_d  = evt_type_q;
      evt_idx_d   = evt_idx_q;
      score_d     = score_q;
      lives_d     = lives_q;
      game_over_d = game_over_q;
      overrun_d   = overrun_q;
      clr_ship    = 1'b0;
      clr_eship   = '0;
      clr_proj    = '0;
      kill        = 1'b0;
      frame_edge  = !fc_sample_q && frame_clk;
      merge       = frame_edge && (state_q != ST_GAMEOVER);

      case (state_q)
         ST_IDLE: begin
            if (frame_edge && any_new) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            overrun_d = overrun_q | frame_edge;
            if (pend_ship_q) begin
               clr_ship   = 1'b1;
               evt_type_d = EVT_SHIP;
               evt_idx_d  = 4'd0;
               state_d    = ST_ISSUE;
            end else if (e_found) begin
               clr_eship  = NE'(1) << e_idx;
               evt_type_d = EVT_ESHIP;
               evt_idx_d  = e_idx;
               state_d    = ST_ISSUE;
            end else if (p_found) begin
               clr_proj   = NP'(1) << p_idx;
               evt_type_d = EVT_PROJ;
               evt_idx_d  = p_idx;
               state_d    = ST_ISSUE;
            end else begin
               // Flags merged this very cycle must not be stranded in IDLE.
               state_d = (frame_edge && any_new) ? ST_SELECT : ST_IDLE;
            end
         end
         ST_ISSUE: begin
            overrun_d = overrun_q | frame_edge;
            if (evt.evt_ready) begin
               state_d = ST_SELECT;
               case (evt_type_q)
                  EVT_SHIP: begin
                     if (lives_q == 2'd1) begin
                        lives_d     = 2'd0;
                        game_over_d = 1'b1;
                        kill        = 1'b1;
                        state_d     = ST_GAMEOVER;
                     end else if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                     end
                  end
                  EVT_ESHIP: score_d = sat_add16(score_q, SCORE_PER_KILL);
                  default: ;
               endcase
            end
         end
         default: ;
      endcase

      pend_ship_d  = (pend_ship_q & ~clr_ship) | (merge & ShipColl);
      pend_eship_d = (pend_eship_q & ~clr_eship) | (merge ? EShipColl : '0);
      pend_proj_d  = (pend_proj_q & ~clr_proj) | (merge ? ProjColl : '0);
      if (kill) begin
         pend_ship_d  = 1'b0;
         pend_eship_d = '0;
         pend_proj_d  = '0;
      end
   end

   always_ff @(posedge pixel_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         fc_sample_q  <= 1'b0;
         pend_ship_q  <= 1'b0;
         pend_eship_q <= '0;
         pend_proj_q  <= '0;
         evt_type_q   <= EVT_NONE;
         evt_idx_q    <= 4'd0;
         score_q      <= 16'd0;
         lives_q      <= START_LIVES;
         game_over_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fc_sample_q  <= fc_sample_d;
         pend_ship_q  <= pend_ship_d;
         pend_eship_q <= pend_eship_d;
         pend_proj_q  <= pend_proj_d;
         evt_type_q   <= evt_type_d;
         evt_idx_q    <= evt_idx_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         game_over_q  <= game_over_d;
         overrun_q    <= overrun_d;
      end
   end

   assign evt.evt_valid = (state_q == ST_ISSUE);
   assign evt.evt_type  = (state_q == ST_ISSUE) ? evt_type_q : EVT_NONE;
   assign evt.evt_idx   = evt_idx_q;
   assign score         = score_q;
   assign lives         = lives_q;
   assign game_over     = game_over_q;
   assign overrun       = overrun_q;

endmodule
